// File: rtl/axilite_arbiter_master_pkg.sv
//------------------------------------------------------------------------------
// axilite_arbiter_master_pkg -- FSM states, AXI response codes, shared helpers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package axilite_arbiter_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/axilite_arbiter_master_if.sv
//------------------------------------------------------------------------------
// axilite_arbiter_master_if -- requester ports plus AXI4-lite master bus
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axilite_arbiter_master_if #(
    parameter int N_PORTS    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [N_PORTS-1:0]            valid_i;
    logic [N_PORTS-1:0]            ready_o;
    logic [N_PORTS*ADDR_WIDTH-1:0] addr_i;
    logic [N_PORTS*DATA_WIDTH-1:0] wdata_i;
    logic [N_PORTS*STRB_WIDTH-1:0] we_i;
    logic [DATA_WIDTH-1:0]         rdata_o;
    logic                          err_o;

    logic                  axi_awvalid;
    logic                  axi_awready;
    logic [ADDR_WIDTH-1:0] axi_awaddr;
    logic [2:0]            axi_awprot;
    logic                  axi_wvalid;
    logic                  axi_wready;
    logic [DATA_WIDTH-1:0] axi_wdata;
    logic [STRB_WIDTH-1:0] axi_wstrb;
    logic                  axi_bvalid;
    logic                  axi_bready;
    logic [1:0]            axi_bresp;
    logic                  axi_arvalid;
    logic                  axi_arready;
    logic [ADDR_WIDTH-1:0] axi_araddr;
    logic [2:0]            axi_arprot;
    logic                  axi_rvalid;
    logic                  axi_rready;
    logic [DATA_WIDTH-1:0] axi_rdata;
    logic [1:0]            axi_rresp;

    modport master (
        input  valid_i, addr_i, wdata_i, we_i,
        output ready_o, rdata_o, err_o,
        output axi_awvalid, axi_awaddr, axi_awprot, input axi_awready,
        output axi_wvalid, axi_wdata, axi_wstrb, input axi_wready,
        input  axi_bvalid, axi_bresp, output axi_bready,
        output axi_arvalid, axi_araddr, axi_arprot, input axi_arready,
        input  axi_rvalid, axi_rdata, axi_rresp, output axi_rready
    );

    modport slave (
        output valid_i, addr_i, wdata_i, we_i,
        input  ready_o, rdata_o, err_o,
        input  axi_awvalid, axi_awaddr, axi_awprot, output axi_awready,
        input  axi_wvalid, axi_wdata, axi_wstrb, output axi_wready,
        output axi_bvalid, axi_bresp, input axi_bready,
        input  axi_arvalid, axi_araddr, axi_arprot, output axi_arready,
        output axi_rvalid, axi_rdata, axi_rresp, input axi_rready
    );

endinterface

`default_nettype wire

// File: rtl/axilite_arbiter_master_rr_arbiter.sv
//------------------------------------------------------------------------------
// axilite_arbiter_master_rr_arbiter -- combinational round-robin priority pick
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axilite_arbiter_master_rr_arbiter
    import axilite_arbiter_master_pkg::*;
#(
    parameter  int N_PORTS = 2,
    localparam int IDX_W   = idx_width(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [N_PORTS-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_req
);

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_PORTS) begin
            sum = sum - N_PORTS;
        end
        return IDX_W'(sum);
    endfunction

    // Scan starting at the pointer; the first requester found wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!any_req && req[wrap_add(ptr, i)]) begin
                any_req   = 1'b1;
                grant_idx = wrap_add(ptr, i);
            end
        end
        grant[grant_idx] = any_req;
    end

endmodule

`default_nettype wire

// File: rtl/axilite_arbiter_master.sv
//------------------------------------------------------------------------------
// axilite_arbiter_master -- N requesters round-robin onto one AXI4-lite master
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module axilite_arbiter_master
    import axilite_arbiter_master_pkg::*;
#(
    parameter int         N_PORTS    = 2,
    parameter int         ADDR_WIDTH = 32,
    parameter int         DATA_WIDTH = 32,
    parameter logic [2:0] AXI_PROT   = AXI_PROT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axilite_arbiter_master_if.master  bus
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = idx_width(N_PORTS);

    state_t state, state_d;

    logic [ADDR_WIDTH-1:0] req_addr  [N_PORTS];
    logic [DATA_WIDTH-1:0] req_wdata [N_PORTS];
    logic [STRB_WIDTH-1:0] req_we    [N_PORTS];

    logic [N_PORTS-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;

    logic [IDX_W-1:0]      rr_ptr, grant_idx;
    logic [N_PORTS-1:0]    grant_oh, ready;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
    logic [STRB_WIDTH-1:0] strb_q;
    logic                  err_q;
    logic                  aw_done, aw_done_d, w_done, w_done_d;
    logic                  awvalid, wvalid, bready, arvalid, rready;

    for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
        assign req_addr[p]  = bus.addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_wdata[p] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        assign req_we[p]    = bus.we_i[p*STRB_WIDTH +: STRB_WIDTH];
    end

    axilite_arbiter_master_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
        .req       (bus.valid_i),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        aw_done_d = aw_done;
        w_done_d  = w_done;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    state_d   = (|req_we[arb_idx]) ? ST_WR : ST_RADDR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            ST_WR: begin
                if (awvalid && bus.axi_awready) aw_done_d = 1'b1;
                if (wvalid && bus.axi_wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)      state_d   = ST_WRESP;
            end
            ST_WRESP: if (bus.axi_bvalid)  state_d = ST_DONE;
            ST_RADDR: if (bus.axi_arready) state_d = ST_RDATA;
            ST_RDATA: if (bus.axi_rvalid)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Bus outputs are computed from the next state so they are flop outputs
    // that line up with the state they belong to.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            ready     <= '0;
            rr_ptr    <= '0;
            grant_idx <= '0;
            grant_oh  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
            awvalid <= (state_d == ST_WR) && !aw_done_d;
            wvalid  <= (state_d == ST_WR) && !w_done_d;
            bready  <= (state_d == ST_WRESP);
            arvalid <= (state_d == ST_RADDR);
            rready  <= (state_d == ST_RDATA);
            ready   <= (state_d == ST_DONE) ? grant_oh : '0;
            if (state == ST_IDLE && arb_any) begin
                grant_idx <= arb_idx;
                grant_oh  <= arb_grant;
                addr_q    <= req_addr[arb_idx];
                wdata_q   <= req_wdata[arb_idx];
                strb_q    <= req_we[arb_idx];
            end
            if (state == ST_WRESP && bus.axi_bvalid) begin
                err_q <= resp_is_err(bus.axi_bresp);
            end
            if (state == ST_RDATA && bus.axi_rvalid) begin
                rdata_q <= bus.axi_rdata;
                err_q   <= resp_is_err(bus.axi_rresp);
            end
            if (state == ST_DONE) begin
                rr_ptr <= (grant_idx == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    assign bus.ready_o     = ready;
    assign bus.rdata_o     = rdata_q;
    assign bus.err_o       = err_q;
    assign bus.axi_awvalid = awvalid;
    assign bus.axi_awaddr  = addr_q;
    assign bus.axi_awprot  = AXI_PROT;
    assign bus.axi_wvalid  = wvalid;
    assign bus.axi_wdata   = wdata_q;
    assign bus.axi_wstrb   = strb_q;
    assign bus.axi_bready  = bready;
    assign bus.axi_arvalid = arvalid;
    assign bus.axi_araddr  = addr_q;
    assign bus.axi_arprot  = AXI_PROT;
    assign bus.axi_rready  = rready;

endmodule

`default_nettype wire

// File: tb/tb_axilite_arbiter_master.sv
//------------------------------------------------------------------------------
// tb_axilite_arbiter_master -- directed bench: 2x32 and 3x64 arbiter instances
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_axilite_arbiter_master;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    axilite_arbiter_master_if #(.N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
    axilite_arbiter_master_if #(.N_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(64)) bus_b ();

    axilite_arbiter_master #(.N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .AXI_PROT(3'b010)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    axilite_arbiter_master #(.N_PORTS(3), .ADDR_WIDTH(32), .DATA_WIDTH(64), .AXI_PROT(3'b000)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Slave model for instance A: configurable AW/W wait, B/R responses.
    int          cfg_aw_wait, cfg_w_wait;
    logic        cfg_r_block, cfg_echo;
    logic [31:0] cfg_rdata;
    logic [1:0]  cfg_bresp, cfg_rresp;
    int          aw_cnt = 0, w_cnt = 0;
    logic        aw_seen, w_seen, aw_hs, w_hs, ar_hs, b_fire;
    logic [31:0] last_awaddr_a, last_wdata_a, last_araddr_a;
    logic [3:0]  last_wstrb_a;
    logic [2:0]  last_arprot_a;

    assign bus_a.axi_awready = bus_a.axi_awvalid && (aw_cnt >= cfg_aw_wait);
    assign bus_a.axi_wready  = bus_a.axi_wvalid && (w_cnt >= cfg_w_wait);
    assign bus_a.axi_arready = bus_a.axi_arvalid;
    assign aw_hs  = bus_a.axi_awvalid && bus_a.axi_awready;
    assign w_hs   = bus_a.axi_wvalid && bus_a.axi_wready;
    assign ar_hs  = bus_a.axi_arvalid && bus_a.axi_arready;
    assign b_fire = (aw_seen || aw_hs) && (w_seen || w_hs) && !bus_a.axi_bvalid;

    always @(posedge clk) begin
        if (!rst_n) begin
            aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0;
            bus_a.axi_bvalid <= 1'b0; bus_a.axi_bresp <= 2'b00;
            bus_a.axi_rvalid <= 1'b0; bus_a.axi_rdata <= '0; bus_a.axi_rresp <= 2'b00;
        end else begin
            aw_cnt  <= (bus_a.axi_awvalid && !bus_a.axi_awready) ? aw_cnt + 1 : 0;
            w_cnt   <= (bus_a.axi_wvalid && !bus_a.axi_wready) ? w_cnt + 1 : 0;
            aw_seen <= b_fire ? 1'b0 : (aw_seen || aw_hs);
            w_seen  <= b_fire ? 1'b0 : (w_seen || w_hs);
            if (bus_a.axi_bvalid && bus_a.axi_bready) bus_a.axi_bvalid <= 1'b0;
            else if (b_fire) begin
                bus_a.axi_bvalid <= 1'b1;
                bus_a.axi_bresp  <= cfg_bresp;
            end
            if (bus_a.axi_rvalid && bus_a.axi_rready) bus_a.axi_rvalid <= 1'b0;
            else if (ar_hs && !cfg_r_block) begin
                bus_a.axi_rvalid <= 1'b1;
                bus_a.axi_rdata  <= cfg_echo ? bus_a.axi_araddr : cfg_rdata;
                bus_a.axi_rresp  <= cfg_rresp;
            end
        end
        if (aw_hs) last_awaddr_a <= bus_a.axi_awaddr;
        if (w_hs) begin
            last_wdata_a <= bus_a.axi_wdata;
            last_wstrb_a <= bus_a.axi_wstrb;
        end
        if (ar_hs) begin
            last_araddr_a <= bus_a.axi_araddr;
            last_arprot_a <= bus_a.axi_arprot;
        end
    end

    // Zero-wait OKAY slave for instance B.
    logic [31:0] last_awaddr_b;
    logic [63:0] last_wdata_b;
    logic [7:0]  last_wstrb_b;

    assign bus_b.axi_awready = bus_b.axi_awvalid;
    assign bus_b.axi_wready  = bus_b.axi_wvalid;
    assign bus_b.axi_arready = bus_b.axi_arvalid;

    always @(posedge clk) begin
        if (!rst_n) begin
            bus_b.axi_bvalid <= 1'b0; bus_b.axi_bresp <= 2'b00;
            bus_b.axi_rvalid <= 1'b0; bus_b.axi_rdata <= '0; bus_b.axi_rresp <= 2'b00;
        end else begin
            if (bus_b.axi_bvalid && bus_b.axi_bready) bus_b.axi_bvalid <= 1'b0;
            else if (bus_b.axi_awvalid && bus_b.axi_awready) bus_b.axi_bvalid <= 1'b1;
            if (bus_b.axi_rvalid && bus_b.axi_rready) bus_b.axi_rvalid <= 1'b0;
            else if (bus_b.axi_arvalid && bus_b.axi_arready) begin
                bus_b.axi_rvalid <= 1'b1;
                bus_b.axi_rdata  <= 64'hFEDC_BA98_7654_3210;
            end
        end
        if (bus_b.axi_awvalid && bus_b.axi_awready) last_awaddr_b <= bus_b.axi_awaddr;
        if (bus_b.axi_wvalid && bus_b.axi_wready) begin
            last_wdata_b <= bus_b.axi_wdata;
            last_wstrb_b <= bus_b.axi_wstrb;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input bit on_b, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (((on_b ? |bus_b.ready_o : |bus_a.ready_o) == 1'b0) && lat < 40);
    endtask

    task automatic req_a(input int port, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
        bus_a.addr_i[port*32 +: 32]  = addr;
        bus_a.wdata_i[port*32 +: 32] = wdata;
        bus_a.we_i[port*4 +: 4]      = we;
        bus_a.valid_i[port]          = 1'b1;
    endtask

    task automatic req_b(input int port, input logic [31:0] addr, input logic [63:0] wdata, input logic [7:0] we);
        bus_b.addr_i[port*32 +: 32]  = addr;
        bus_b.wdata_i[port*64 +: 64] = wdata;
        bus_b.we_i[port*8 +: 8]      = we;
        bus_b.valid_i[port]          = 1'b1;
    endtask

    function automatic logic [4:0] axi_vld_a();
        return {bus_a.axi_awvalid, bus_a.axi_wvalid, bus_a.axi_arvalid, bus_a.axi_bready, bus_a.axi_rready};
    endfunction

    initial begin
        int lat;
        rst_n = 1'b0;
        bus_a.valid_i = '0; bus_a.addr_i = '0; bus_a.wdata_i = '0; bus_a.we_i = '0;
        bus_b.valid_i = '0; bus_b.addr_i = '0; bus_b.wdata_i = '0; bus_b.we_i = '0;
        cfg_aw_wait = 0; cfg_w_wait = 0; cfg_r_block = 1'b0; cfg_echo = 1'b0;
        cfg_rdata = '0; cfg_bresp = 2'b00; cfg_rresp = 2'b00;

        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bus_a.ready_o), 64'h0);
        check("rst_axi_vld", 64'(axi_vld_a()), 64'h0);
        check("rst_rdata", 64'(bus_a.rdata_o), 64'h0);
        check("rst_err", 64'(bus_a.err_o), 64'h0);
        check("rst_awaddr", 64'(bus_a.axi_awaddr), 64'h0);
        check("rst_b_vld", 64'({bus_b.ready_o, bus_b.axi_awvalid, bus_b.axi_arvalid}), 64'h0);
        rst_n = 1'b1;

        // Port 0 zero-wait read
        @(negedge clk);
        cfg_rdata = 32'hDEAD_BEEF;
        req_a(0, 32'h0000_0100, 32'h0, 4'h0);
        wait_ready(1'b0, lat);
        check("rd_lat", 64'(lat), 64'd3);
        check("rd_ready", 64'(bus_a.ready_o), 64'h1);
        check("rd_rdata", 64'(bus_a.rdata_o), 64'hDEAD_BEEF);
        check("rd_err", 64'(bus_a.err_o), 64'h0);
        check("rd_araddr", 64'(last_araddr_a), 64'h100);
        check("rd_arprot", 64'(last_arprot_a), 64'h2);
        bus_a.valid_i = '0;
        @(negedge clk);
        check("rd_pulse", 64'(bus_a.ready_o), 64'h0);

        // Port 1 write, W accepted 3 cycles before AW
        cfg_aw_wait = 3;
        req_a(1, 32'h2000_0004, 32'h1234_5678, 4'b0011);
        @(negedge clk);
        check("wr_aw_w_c1", 64'({bus_a.axi_awvalid, bus_a.axi_wvalid}), 64'h3);
        @(negedge clk);
        check("wr_aw_w_c2", 64'({bus_a.axi_awvalid, bus_a.axi_wvalid}), 64'h2);
        wait_ready(1'b0, lat);
        check("wr_lat", 64'(lat + 2), 64'd6);
        check("wr_ready", 64'(bus_a.ready_o), 64'h2);
        check("wr_awaddr", 64'(last_awaddr_a), 64'h2000_0004);
        check("wr_wdata", 64'(last_wdata_a), 64'h1234_5678);
        check("wr_wstrb", 64'(last_wstrb_a), 64'h3);
        check("wr_err", 64'(bus_a.err_o), 64'h0);
        check("wr_rdata_hold", 64'(bus_a.rdata_o), 64'hDEAD_BEEF);
        bus_a.valid_i = '0;
        cfg_aw_wait = 0;
        @(negedge clk);
        check("wr_pulse", 64'(bus_a.ready_o), 64'h0);

        // Both ports reading continuously: grants alternate 0,1,0,1
        cfg_echo = 1'b1;
        req_a(0, 32'h0000_0A00, 32'h0, 4'h0);
        req_a(1, 32'h0000_0B00, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            logic [1:0]  exp_rdy;
            logic [31:0] exp_dat;
            exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_dat = (k % 2 == 0) ? 32'h0000_0A00 : 32'h0000_0B00;
            wait_ready(1'b0, lat);
            check($sformatf("rr_ready%0d", k), 64'(bus_a.ready_o), 64'(exp_rdy));
            check($sformatf("rr_rdata%0d", k), 64'(bus_a.rdata_o), 64'(exp_dat));
        end
        bus_a.valid_i = '0;
        cfg_echo = 1'b0;
        @(negedge clk);
        check("rr_pulse", 64'(bus_a.ready_o), 64'h0);

        // Write with SLVERR, then clean read
        cfg_bresp = 2'b10;
        req_a(0, 32'h0000_0040, 32'hAAAA_5555, 4'hF);
        wait_ready(1'b0, lat);
        check("slverr_lat", 64'(lat), 64'd3);
        check("slverr_ready", 64'(bus_a.ready_o), 64'h1);
        check("slverr_err", 64'(bus_a.err_o), 64'h1);
        check("slverr_rdata_hold", 64'(bus_a.rdata_o), 64'h0000_0B00);
        bus_a.valid_i = '0;
        cfg_bresp = 2'b00;
        @(negedge clk);
        cfg_rdata = 32'h0BAD_F00D;
        req_a(1, 32'h0000_0C00, 32'h0, 4'h0);
        wait_ready(1'b0, lat);
        check("okay_ready", 64'(bus_a.ready_o), 64'h2);
        check("okay_err", 64'(bus_a.err_o), 64'h0);
        check("okay_rdata", 64'(bus_a.rdata_o), 64'h0BAD_F00D);
        bus_a.valid_i = '0;
        @(negedge clk);

        // Reset while waiting for R
        cfg_r_block = 1'b1;
        req_a(0, 32'h0000_0300, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("mid_in_rdata", 64'(bus_a.axi_rready), 64'h1);
        rst_n = 1'b0;
        bus_a.valid_i = '0;
        @(negedge clk);
        check("mid_ready", 64'(bus_a.ready_o), 64'h0);
        check("mid_axi_vld", 64'(axi_vld_a()), 64'h0);
        check("mid_rdata", 64'(bus_a.rdata_o), 64'h0);
        check("mid_araddr", 64'(bus_a.axi_araddr), 64'h0);
        rst_n = 1'b1;
        cfg_r_block = 1'b0;
        cfg_rdata = 32'h1357_9BDF;
        @(negedge clk);
        req_a(0, 32'h0000_0300, 32'h0, 4'h0);
        wait_ready(1'b0, lat);
        check("post_lat", 64'(lat), 64'd3);
        check("post_ready", 64'(bus_a.ready_o), 64'h1);
        check("post_rdata", 64'(bus_a.rdata_o), 64'h1357_9BDF);
        bus_a.valid_i = '0;

        // 3-port 64-bit instance: upper-half write on port 2, then pointer wrap
        req_b(2, 32'h8000_0010, 64'h1122_3344_5566_7788, 8'hF0);
        wait_ready(1'b1, lat);
        check("b_wr_lat", 64'(lat), 64'd3);
        check("b_wr_ready", 64'(bus_b.ready_o), 64'h4);
        check("b_wr_wstrb", 64'(last_wstrb_b), 64'hF0);
        check("b_wr_wdata_hi", 64'(last_wdata_b[63:32]), 64'h1122_3344);
        check("b_wr_wdata", last_wdata_b, 64'h1122_3344_5566_7788);
        check("b_wr_awaddr", 64'(last_awaddr_b), 64'h8000_0010);
        bus_b.valid_i = '0;
        @(negedge clk);
        req_b(0, 32'h0000_0010, 64'h0, 8'h0);
        req_b(1, 32'h0000_0020, 64'h0, 8'h0);
        wait_ready(1'b1, lat);
        check("b_wrap_ready", 64'(bus_b.ready_o), 64'h1);
        check("b_rd_rdata", bus_b.rdata_o, 64'hFEDC_BA98_7654_3210);
        bus_b.valid_i[0] = 1'b0;
        wait_ready(1'b1, lat);
        check("b_next_ready", 64'(bus_b.ready_o), 64'h2);
        bus_b.valid_i = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
